// File: rtl/axi_slave_mem_param.sv
// axi_slave_mem_param: AXI3-style slave memory with concurrent read/write FSMs, FIXED/INCR/WRAP bursts and DECERR window
module axi_slave_mem_param #(
    parameter int DATA_W   = 128,
    parameter int ADDR_W   = 40,
    parameter int ID_W     = 8,
    parameter int MEM_AW   = 16,
    parameter int READ_LAT = 1
) (
    input  logic                pad_cpu_rst_b,
    input  logic                pll_core_cpuclk,
    input  logic [ID_W-1:0]     awid_s0,
    input  logic [ADDR_W-1:0]   awaddr_s0,
    input  logic [7:0]          awlen_s0,
    input  logic [1:0]          awburst_s0,
    input  logic                awvalid_s0,
    output logic                awready_s0,
    input  logic [DATA_W-1:0]   wdata_s0,
    input  logic [DATA_W/8-1:0] wstrb_s0,
    input  logic                wlast_s0,
    input  logic                wvalid_s0,
    output logic                wready_s0,
    output logic [ID_W-1:0]     bid_s0,
    output logic [1:0]          bresp_s0,
    output logic                bvalid_s0,
    input  logic                bready_s0,
    input  logic [ID_W-1:0]     arid_s0,
    input  logic [ADDR_W-1:0]   araddr_s0,
    input  logic [7:0]          arlen_s0,
    input  logic [1:0]          arburst_s0,
    input  logic                arvalid_s0,
    output logic                arready_s0,
    output logic [ID_W-1:0]     rid_s0,
    output logic [DATA_W-1:0]   rdata_s0,
    output logic [1:0]          rresp_s0,
    output logic                rlast_s0,
    output logic                rvalid_s0,
    input  logic                rready_s0
);
    localparam int B  = DATA_W / 8;
    localparam int LB = $clog2(B);
    localparam int HI = MEM_AW + LB;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    logic [DATA_W-1:0] mem [2**MEM_AW];

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [7:0] len,
                                                    input logic [1:0] burst);
        logic [ADDR_W-1:0] inc, mask;
        inc  = a + ADDR_W'(B);
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << LB) - ADDR_W'(1);
        next_addr = burst == 2'b01 ? inc : burst == 2'b10 ? (a & ~mask) | (inc & mask) : a;
    endfunction

    function automatic logic illegal(input logic [7:0] len, input logic [1:0] burst);
        illegal = burst == 2'b11 || (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    endfunction

    w_state_t          w_state, w_next;
    logic [ID_W-1:0]   w_id;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_len, w_cnt;
    logic [1:0]        w_burst;
    logic              w_slv, w_dec, w_oor, aw_hs, w_hs, b_hs;

    assign aw_hs     = awvalid_s0 && awready_s0;
    assign w_hs      = wvalid_s0 && wready_s0;
    assign b_hs      = bvalid_s0 && bready_s0;
    assign w_oor     = |w_addr[ADDR_W-1:HI];
    assign wready_s0 = w_state == W_DATA;
    assign bvalid_s0 = w_state == W_RESP;
    assign bid_s0    = w_id;
    assign bresp_s0  = w_slv ? 2'b10 : w_dec ? 2'b11 : 2'b00;

    // write channel next state
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_cnt == w_len) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // write state register; awready tracks the state about to be entered
    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b)
        if (!pad_cpu_rst_b) begin
            w_state    <= W_IDLE;
            awready_s0 <= 1'b0;
        end else begin
            w_state    <= w_next;
            awready_s0 <= w_next == W_IDLE;
        end

    // write burst bookkeeping and sticky error flags
    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b)
        if (!pad_cpu_rst_b) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_slv   <= 1'b0;
            w_dec   <= 1'b0;
        end else if (aw_hs) begin
            w_id    <= awid_s0;
            w_addr  <= awaddr_s0 & ~ADDR_W'(B - 1);
            w_len   <= awlen_s0;
            w_burst <= awburst_s0;
            w_cnt   <= '0;
            w_slv   <= illegal(awlen_s0, awburst_s0);
            w_dec   <= 1'b0;
        end else if (w_hs) begin
            w_cnt  <= w_cnt + 8'd1;
            w_addr <= next_addr(w_addr, w_len, w_burst);
            if (w_oor) w_dec <= 1'b1;
            if (wlast_s0 != (w_cnt == w_len)) w_slv <= 1'b1;
        end

    // byte-strobed memory write; beats outside the window are dropped
    always_ff @(posedge pll_core_cpuclk)
        if (w_hs && !w_oor)
            for (int i = 0; i < B; i++)
                if (wstrb_s0[i]) mem[w_addr[HI-1:LB]][i*8 +: 8] <= wdata_s0[i*8 +: 8];

    r_state_t          r_state, r_next;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len, r_cnt;
    logic [1:0]        r_burst;
    logic [3:0]        r_lat;
    logic              r_slv, r_oor, ar_hs, r_hs;

    assign ar_hs     = arvalid_s0 && arready_s0;
    assign r_hs      = rvalid_s0 && rready_s0;
    assign r_oor     = |r_addr[ADDR_W-1:HI];
    assign rvalid_s0 = r_state == R_DATA;
    assign rid_s0    = r_id;

    // read channel next state
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_FETCH;
            R_FETCH: if (r_lat == 4'(READ_LAT - 1)) r_next = R_DATA;
            R_DATA:  if (r_hs) r_next = rlast_s0 ? R_IDLE : R_FETCH;
            default: r_next = R_IDLE;
        endcase
    end

    // read state register; arready tracks the state about to be entered
    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b)
        if (!pad_cpu_rst_b) begin
            r_state    <= R_IDLE;
            arready_s0 <= 1'b0;
        end else begin
            r_state    <= r_next;
            arready_s0 <= r_next == R_IDLE;
        end

    // read datapath: memory is sampled on the first fetch cycle and held until accepted
    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b)
        if (!pad_cpu_rst_b) begin
            r_id     <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_burst  <= '0;
            r_cnt    <= '0;
            r_slv    <= 1'b0;
            r_lat    <= '0;
            rdata_s0 <= '0;
            rresp_s0 <= '0;
            rlast_s0 <= 1'b0;
        end else begin
            r_lat <= r_state == R_FETCH ? r_lat + 4'd1 : 4'd0;
            if (ar_hs) begin
                r_id    <= arid_s0;
                r_addr  <= araddr_s0 & ~ADDR_W'(B - 1);
                r_len   <= arlen_s0;
                r_burst <= arburst_s0;
                r_cnt   <= '0;
                r_slv   <= illegal(arlen_s0, arburst_s0);
            end
            if (r_state == R_FETCH && r_lat == 4'd0) begin
                rdata_s0 <= r_oor ? '0 : mem[r_addr[HI-1:LB]];
                rresp_s0 <= r_slv ? 2'b10 : r_oor ? 2'b11 : 2'b00;
                rlast_s0 <= r_cnt == r_len;
            end
            if (r_hs && !rlast_s0) begin
                r_cnt  <= r_cnt + 8'd1;
                r_addr <= next_addr(r_addr, r_len, r_burst);
            end
        end
endmodule

// File: tb/tb_axi_slave_mem_param.sv
// tb_axi_slave_mem_param: randomized bench for axi_slave_mem_param against a byte-addressed reference memory
module tb_axi_slave_mem_param;
    localparam longint LIMIT = 64'h4000;

    logic clk, rst_b;
    logic [7:0] awid, arid, bid, rid, awlen, arlen;
    logic [39:0] awaddr, araddr;
    logic [1:0] awburst, arburst, bresp, rresp;
    logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic arvalid, arready, rvalid, rready, rlast;
    logic [127:0] wdata, rdata;
    logic [15:0] wstrb;

    int cmp, err;
    logic [127:0] wr_data [256];
    logic [15:0]  wr_strb [256];
    logic [127:0] rd_data [256];
    logic [1:0]   rd_resp [256];
    logic         rd_last [256];
    logic [7:0]   rd_id   [256];
    int rd_n, rd_stall;
    bit rd_to;
    logic [1:0] b_resp;
    logic [7:0] b_id;
    bit [7:0] mb [longint];

    axi_slave_mem_param #(.DATA_W(128), .ADDR_W(40), .ID_W(8), .MEM_AW(10), .READ_LAT(2)) dut (
        .pad_cpu_rst_b(rst_b), .pll_core_cpuclk(clk),
        .awid_s0(awid), .awaddr_s0(awaddr), .awlen_s0(awlen), .awburst_s0(awburst),
        .awvalid_s0(awvalid), .awready_s0(awready),
        .wdata_s0(wdata), .wstrb_s0(wstrb), .wlast_s0(wlast), .wvalid_s0(wvalid), .wready_s0(wready),
        .bid_s0(bid), .bresp_s0(bresp), .bvalid_s0(bvalid), .bready_s0(bready),
        .arid_s0(arid), .araddr_s0(araddr), .arlen_s0(arlen), .arburst_s0(arburst),
        .arvalid_s0(arvalid), .arready_s0(arready),
        .rid_s0(rid), .rdata_s0(rdata), .rresp_s0(rresp), .rlast_s0(rlast),
        .rvalid_s0(rvalid), .rready_s0(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint beat_addr(longint a, int len, int burst, int i);
        longint a0, win, base;
        a0 = a - (a % 16);
        if (burst == 1) return (a0 + longint'(i) * 16) & 64'hFF_FFFF_FFFF;
        if (burst == 2) begin
            win = longint'(len + 1) * 16;
            base = a0 - (a0 % win);
            return base + ((a0 - base + longint'(i) * 16) % win);
        end
        return a0;
    endfunction

    function automatic void model_write(longint a, int len, int burst);
        longint ba;
        for (int i = 0; i <= len; i++) begin
            ba = beat_addr(a, len, burst, i);
            if (ba < LIMIT)
                for (int j = 0; j < 16; j++)
                    if (wr_strb[i][j]) mb[ba + j] = wr_data[i][j*8 +: 8];
        end
    endfunction

    function automatic void model_read(longint a, output logic [127:0] d, output logic [127:0] m);
        d = '0;
        m = '0;
        if (a >= LIMIT) begin
            m = '1;
            return;
        end
        for (int j = 0; j < 16; j++)
            if (mb.exists(a + j)) begin
                d[j*8 +: 8] = mb[a + j];
                m[j*8 +: 8] = 8'hFF;
            end
    endfunction

    task automatic do_write(input logic [7:0] id, input logic [39:0] a, input logic [7:0] len,
                            input logic [1:0] burst, input bit rnd, input int lastpos);
        int n = 0, i = 0;
        bit ok = 0;
        awid = id; awaddr = a; awlen = len; awburst = burst; awvalid = 1;
        while (!awready && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        awvalid = 0;
        n = 0;
        while (i <= int'(len) && n < 2000) begin
            wvalid = !rnd || ($urandom_range(0, 3) != 0);
            wdata = wr_data[i]; wstrb = wr_strb[i]; wlast = (i == lastpos);
            if (wvalid && wready) i++;
            @(negedge clk); n++;
        end
        wvalid = 0; wlast = 0;
        n = 0;
        b_resp = 2'b01; b_id = ~id;
        while (!ok && n < 2000) begin
            bready = !rnd || ($urandom_range(0, 2) == 0);
            if (bvalid && bready) begin b_resp = bresp; b_id = bid; ok = 1; end
            @(negedge clk); n++;
        end
        bready = 0;
    endtask

    task automatic ar_go(input logic [7:0] id, input logic [39:0] a, input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        arid = id; araddr = a; arlen = len; arburst = burst; arvalid = 1;
        while (!arready && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 0;
        rd_to = n >= 200;
    endtask

    task automatic do_read(input logic [7:0] id, input logic [39:0] a, input logic [7:0] len,
                           input logic [1:0] burst, input bit rnd);
        int n = 0;
        bit pend = 0, rr;
        logic [127:0] pd;
        logic [1:0] pr;
        logic pl;
        logic [7:0] pi;
        rd_n = 0; rd_stall = 0;
        ar_go(id, a, len, burst);
        while (rd_n <= int'(len) && n < 4000) begin
            if (pend && (rvalid !== 1'b1 || rdata !== pd || rresp !== pr || rlast !== pl || rid !== pi)) rd_stall++;
            rr = !rnd || ($urandom_range(0, 2) != 0);
            rready = rr;
            pend = rvalid && !rr; pd = rdata; pr = rresp; pl = rlast; pi = rid;
            if (rvalid && rr) begin
                rd_data[rd_n] = rdata; rd_resp[rd_n] = rresp; rd_last[rd_n] = rlast; rd_id[rd_n] = rid;
                rd_n++;
            end
            @(negedge clk); n++;
        end
        rready = 0;
        if (rd_to) rd_n = -1;
    endtask

    task automatic test_reset();
        {awvalid, wvalid, bready, arvalid, rready, wlast} = '0;
        {awid, awaddr, awlen, awburst, wdata, wstrb, arid, araddr, arlen, arburst} = '0;
        rst_b = 1; #2 rst_b = 0;
        repeat (3) @(negedge clk);
        cmp++; if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b0)
            begin err++; $display("FAIL reset_ctl: got %b want 000000", {awready, arready, wready, bvalid, rvalid, rlast}); end
        cmp++; if ({bresp, rresp, bid, rid} !== 20'h0)
            begin err++; $display("FAIL reset_resp_id: got %h want 0", {bresp, rresp, bid, rid}); end
        cmp++; if (rdata !== 128'h0) begin err++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        rst_b = 1;
        #1;
        cmp++; if ({awready, arready} !== 2'b00) begin err++; $display("FAIL ready_pre_clk: got %b want 00", {awready, arready}); end
        @(posedge clk); #1;
        cmp++; if ({awready, arready} !== 2'b11) begin err++; $display("FAIL ready_post_clk: got %b want 11", {awready, arready}); end
        @(negedge clk);
    endtask

    task automatic test_prefill();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 16; i++) begin
                wr_data[i] = {$urandom, $urandom, $urandom, $urandom}; wr_strb[i] = 16'hFFFF;
            end
            do_write(8'(k), 40'(k * 'h100), 8'd15, 2'd1, 1'b0, 15);
            cmp++; if (b_resp !== 2'b00) begin err++; $display("FAIL prefill_bresp[%0d]: got %0d want 0", k, b_resp); end
            model_write(k * 'h100, 15, 1);
        end
    endtask

    task automatic test_incr();
        for (int i = 0; i < 4; i++) begin wr_data[i] = 128'(8'hA0 + i); wr_strb[i] = 16'hFFFF; end
        do_write(8'h5A, 40'h100, 8'd3, 2'd1, 1'b0, 3);
        cmp++; if ({b_resp, b_id} !== {2'b00, 8'h5A}) begin err++; $display("FAIL incr_b: got %h want 05a", {b_resp, b_id}); end
        model_write('h100, 3, 1);
        do_read(8'h3C, 40'h100, 8'd3, 2'd1, 1'b0);
        cmp++; if (rd_n !== 4) begin err++; $display("FAIL incr_beats: got %0d want 4", rd_n); end
        for (int i = 0; i < 4; i++) begin
            cmp++; if (rd_data[i] !== 128'(8'hA0 + i)) begin err++; $display("FAIL incr_data[%0d]: got %h want %h", i, rd_data[i], 8'hA0 + i); end
            cmp++; if ({rd_resp[i], rd_last[i], rd_id[i]} !== {2'b00, i == 3, 8'h3C})
                begin err++; $display("FAIL incr_ctl[%0d]: got %h want %h", i, {rd_resp[i], rd_last[i], rd_id[i]}, {2'b00, i == 3, 8'h3C}); end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] e [4] = '{8'hA3, 8'hA0, 8'hA1, 8'hA2};
        do_read(8'h21, 40'h130, 8'd3, 2'd2, 1'b0);
        cmp++; if (rd_n !== 4) begin err++; $display("FAIL wrap_beats: got %0d want 4", rd_n); end
        for (int i = 0; i < 4; i++) begin
            cmp++; if (rd_data[i] !== 128'(e[i])) begin err++; $display("FAIL wrap_data[%0d]: got %h want %h", i, rd_data[i], e[i]); end
            cmp++; if ({rd_resp[i], rd_last[i]} !== {2'b00, i == 3}) begin err++; $display("FAIL wrap_ctl[%0d]: got %b", i, {rd_resp[i], rd_last[i]}); end
        end
    endtask

    task automatic test_strobe();
        logic [127:0] old, m, exp;
        model_read('h200, old, m);
        exp = {old[127:64], 64'h1111_1111_1111_1111};
        wr_data[0] = {16{8'h11}}; wr_strb[0] = 16'h00FF;
        do_write(8'h07, 40'h200, 8'd0, 2'd1, 1'b0, 0);
        cmp++; if (b_resp !== 2'b00) begin err++; $display("FAIL strobe_bresp: got %0d want 0", b_resp); end
        model_write('h200, 0, 1);
        do_read(8'h08, 40'h200, 8'd0, 2'd1, 1'b0);
        cmp++; if (rd_data[0] !== exp || rd_n !== 1) begin err++; $display("FAIL strobe_data: got %h want %h", rd_data[0], exp); end
    endtask

    task automatic test_decerr();
        logic [127:0] ed, em;
        wr_data[0] = {4{32'hDEAD_BEEF}}; wr_strb[0] = 16'hFFFF;
        do_write(8'h44, 40'h4100, 8'd0, 2'd1, 1'b0, 0);
        cmp++; if ({b_resp, b_id} !== {2'b11, 8'h44}) begin err++; $display("FAIL decerr_b: got %h want 344", {b_resp, b_id}); end
        do_read(8'h45, 40'h100, 8'd0, 2'd1, 1'b0);
        cmp++; if (rd_data[0] !== 128'hA0) begin err++; $display("FAIL decerr_alias: got %h want a0", rd_data[0]); end
        do_read(8'h46, 40'h4100, 8'd0, 2'd1, 1'b0);
        cmp++; if ({rd_data[0], rd_resp[0], rd_last[0]} !== {128'h0, 2'b11, 1'b1})
            begin err++; $display("FAIL decerr_read: got %h resp %0d", rd_data[0], rd_resp[0]); end
        for (int i = 0; i < 2; i++) begin wr_data[i] = {$urandom, $urandom, $urandom, $urandom}; wr_strb[i] = 16'hFFFF; end
        do_write(8'h47, 40'h3FF0, 8'd1, 2'd1, 1'b0, 1);
        cmp++; if (b_resp !== 2'b11) begin err++; $display("FAIL edge_bresp: got %0d want 3", b_resp); end
        model_write('h3FF0, 1, 1);
        do_read(8'h48, 40'h3FF0, 8'd1, 2'd1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            model_read(beat_addr('h3FF0, 1, 1, i), ed, em);
            cmp++; if ({rd_data[i] & em, rd_resp[i]} !== {ed & em, i == 1 ? 2'b11 : 2'b00})
                begin err++; $display("FAIL edge_read[%0d]: got %h resp %0d want %h", i, rd_data[i], rd_resp[i], ed); end
        end
    endtask

    task automatic test_illegal();
        wr_strb[0] = 16'hFFFF; wr_strb[1] = 16'hFFFF; wr_strb[2] = 16'hFFFF;
        do_write(8'h50, 40'h1000, 8'd1, 2'd3, 1'b0, 1);
        cmp++; if (b_resp !== 2'b10) begin err++; $display("FAIL illegal_b11: got %0d want 2", b_resp); end
        do_write(8'h51, 40'h1000, 8'd2, 2'd2, 1'b0, 2);
        cmp++; if (b_resp !== 2'b10) begin err++; $display("FAIL illegal_wrap3: got %0d want 2", b_resp); end
        do_read(8'h52, 40'h1000, 8'd4, 2'd2, 1'b0);
        cmp++; if (rd_n !== 5) begin err++; $display("FAIL illegal_beats: got %0d want 5", rd_n); end
        for (int i = 0; i < 5; i++) begin
            cmp++; if ({rd_resp[i], rd_last[i]} !== {2'b10, i == 4}) begin err++; $display("FAIL illegal_r[%0d]: got %b", i, {rd_resp[i], rd_last[i]}); end
        end
    endtask

    task automatic test_wlast();
        for (int i = 0; i < 4; i++) wr_strb[i] = 16'hFFFF;
        do_write(8'h60, 40'h1100, 8'd3, 2'd1, 1'b0, 1);
        cmp++; if (b_resp !== 2'b10) begin err++; $display("FAIL wlast_early: got %0d want 2", b_resp); end
        do_write(8'h61, 40'h1100, 8'd2, 2'd1, 1'b0, 255);
        cmp++; if (b_resp !== 2'b10) begin err++; $display("FAIL wlast_missing: got %0d want 2", b_resp); end
        do_write(8'h62, 40'h4000, 8'd0, 2'd0, 1'b0, 255);
        cmp++; if (b_resp !== 2'b10) begin err++; $display("FAIL resp_priority: got %0d want 2", b_resp); end
    endtask

    task automatic test_random();
        int wl [4] = '{1, 3, 7, 15};
        logic [7:0] len, id;
        logic [1:0] burst;
        logic [39:0] a;
        logic [127:0] ed, em;
        for (int t = 0; t < 16; t++) begin
            burst = 2'($urandom_range(0, 2));
            len = burst == 2'd2 ? 8'(wl[$urandom_range(0, 3)]) : 8'($urandom_range(0, 7));
            a = 40'($urandom_range(0, 'h37F));
            id = 8'($urandom);
            for (int i = 0; i <= int'(len); i++) begin
                wr_data[i] = {$urandom, $urandom, $urandom, $urandom}; wr_strb[i] = 16'($urandom);
            end
            do_write(id, a, len, burst, 1'b1, int'(len));
            cmp++; if ({b_resp, b_id} !== {2'b00, id}) begin err++; $display("FAIL rand_b[%0d]: got %h want %h", t, {b_resp, b_id}, {2'b00, id}); end
            model_write(a, len, burst);
            do_read(~id, a, len, burst, 1'b1);
            cmp++; if (rd_n !== int'(len) + 1 || rd_stall !== 0) begin err++; $display("FAIL rand_flow[%0d]: got beats %0d stalls %0d", t, rd_n, rd_stall); end
            for (int i = 0; i <= int'(len); i++) begin
                model_read(beat_addr(a, len, burst, i), ed, em);
                cmp++; if ((rd_data[i] & em) !== (ed & em)) begin err++; $display("FAIL rand_data[%0d.%0d]: got %h want %h", t, i, rd_data[i] & em, ed & em); end
                cmp++; if ({rd_resp[i], rd_last[i], rd_id[i]} !== {2'b00, i == int'(len), ~id})
                    begin err++; $display("FAIL rand_ctl[%0d.%0d]: got %h", t, i, {rd_resp[i], rd_last[i], rd_id[i]}); end
            end
        end
    endtask

    task automatic test_concurrent();
        logic [127:0] ed [8], em [8];
        logic [127:0] d, m;
        for (int i = 0; i < 8; i++) begin
            wr_data[i] = {$urandom, $urandom, $urandom, $urandom}; wr_strb[i] = 16'hFFFF;
            model_read('h280 + i * 16, ed[i], em[i]);
        end
        fork
            do_write(8'h90, 40'h000, 8'd7, 2'd1, 1'b1, 7);
            do_read(8'h91, 40'h280, 8'd7, 2'd1, 1'b1);
        join
        cmp++; if ({b_resp, b_id} !== {2'b00, 8'h90}) begin err++; $display("FAIL conc_b: got %h want 090", {b_resp, b_id}); end
        cmp++; if (rd_n !== 8 || rd_stall !== 0) begin err++; $display("FAIL conc_flow: got beats %0d stalls %0d", rd_n, rd_stall); end
        for (int i = 0; i < 8; i++) begin
            cmp++; if ((rd_data[i] & em[i]) !== (ed[i] & em[i]) || rd_last[i] !== (i == 7))
                begin err++; $display("FAIL conc_rdata[%0d]: got %h want %h", i, rd_data[i], ed[i]); end
        end
        model_write('h000, 7, 1);
        do_read(8'h92, 40'h000, 8'd7, 2'd1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            model_read(i * 16, d, m);
            cmp++; if (rd_data[i] !== d) begin err++; $display("FAIL conc_wdata[%0d]: got %h want %h", i, rd_data[i], d); end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0, got = 0;
        logic [127:0] d, m;
        ar_go(8'h77, 40'h000, 8'd7, 2'd1);
        rready = 1;
        while (n < 100) begin
            if (rvalid) begin
                if (got == 1) break;
                got++;
            end
            @(negedge clk); n++;
        end
        cmp++; if (n >= 100) begin err++; $display("FAIL rstmid_beat2: got %0d beats want 1", got); end
        rst_b = 0;
        #1;
        cmp++; if ({rvalid, rlast, arready} !== 3'b000 || rdata !== 128'h0)
            begin err++; $display("FAIL rstmid_abort: got %b %h want 000 0", {rvalid, rlast, arready}, rdata); end
        rready = 0;
        @(negedge clk);
        rst_b = 1;
        repeat (2) @(negedge clk);
        do_read(8'h78, 40'h000, 8'd7, 2'd1, 1'b0);
        cmp++; if (rd_n !== 8) begin err++; $display("FAIL rstmid_beats: got %0d want 8", rd_n); end
        for (int i = 0; i < 8; i++) begin
            model_read(i * 16, d, m);
            cmp++; if ({rd_data[i], rd_last[i]} !== {d, i == 7}) begin err++; $display("FAIL rstmid_data[%0d]: got %h want %h", i, rd_data[i], d); end
        end
    endtask

    initial begin
        cmp = 0; err = 0;
        test_reset();
        test_prefill();
        test_incr();
        test_wrap();
        test_strobe();
        test_decerr();
        test_illegal();
        test_wlast();
        test_random();
        test_concurrent();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule

// File: doc/axi_slave_mem_param.md
Name: axi_slave_mem_param

Overview:
Parametrised AXI3-style slave memory model for the smart_run testbench. It has independent read and write channel FSMs that run concurrently. It supports FIXED, INCR and WRAP bursts of any length, and returns DECERR for addresses outside the memory window. It attaches to the bus matrix slave port in place of fixed-width, single-FSM slave models.

Parameters:
DATA_W, 128, data bus width in bits; power of two, 32..512
ADDR_W, 40, AXI address width
ID_W, 8, AXI ID width
MEM_AW, 16, log2 of memory depth in DATA_W words
READ_LAT, 1, cycles from fetch to rvalid; range 1..8

Ports:
pad_cpu_rst_b  in  1  asynchronous active-low reset
pll_core_cpuclk  in  1  clock
awid_s0/awaddr_s0/awlen_s0/awburst_s0  in  ID_W/ADDR_W/8/2  write address
awvalid_s0  in  1  write address valid
awready_s0  out  1  write address ready
wdata_s0/wstrb_s0/wlast_s0  in  DATA_W/DATA_W/8/1  write data, byte strobe, last
wvalid_s0  in  1  write data valid
wready_s0  out  1  write data ready
bid_s0/bresp_s0  out  ID_W/2  write response ID and code
bvalid_s0  out  1  write response valid
bready_s0  in  1  write response ready
arid_s0/araddr_s0/arlen_s0/arburst_s0  in  ID_W/ADDR_W/8/2  read address
arvalid_s0  in  1  read address valid
arready_s0  out  1  read address ready
rid_s0/rdata_s0/rresp_s0/rlast_s0  out  ID_W/DATA_W/2/1  read data channel
rvalid_s0  out  1  read data valid
rready_s0  in  1  read data ready

Behaviour:
- Clock and reset: clock pll_core_cpuclk; reset pad_cpu_rst_b, asynchronous, active-low.
- Reset values: all ready, valid, resp, id, last and data outputs are 0. Both FSMs go to IDLE. Memory contents are not reset.
- awready_s0 and arready_s0 are registered. They rise on the first clock after reset release.
- Beat size is always DATA_W/8 bytes (B). The low log2(B) address bits are ignored; addresses are word-aligned on capture.
- Word index = addr[MEM_AW+log2(B)-1 : log2(B)].
- Out of range: any address bit at or above MEM_AW+log2(B) is set.
- Next address per beat:
  - FIXED: unchanged.
  - INCR: +B, wrapping modulo 2^ADDR_W.
  - WRAP: window = (len+1)*B. Next = (addr & ~(window-1)) | ((addr+B) & (window-1)).
- Legal WRAP lengths are len+1 in {2,4,8,16}. Any other WRAP length, or burst=2'b11, flags SLVERR for the whole burst.
- Write FSM states:
  - W_IDLE: awready=1. On AW handshake, capture id/addr/len/burst, clear the error flags, go to W_DATA. awready drops the next cycle.
  - W_DATA: wready=1. Each W handshake writes the bytes where wstrb=1, unless the beat is out of range (write suppressed, sticky DECERR). Beat counter increments. On the beat where count==awlen, go to W_RESP.
  - wlast mismatch (early wlast, or no wlast on the final beat) sets sticky SLVERR; the burst length always follows awlen.
  - W_RESP: bvalid=1, bid=captured awid. bresp priority: SLVERR(2'b10) > DECERR(2'b11) > OKAY. bvalid and bresp are held until bready, then go to W_IDLE.
- Read FSM states:
  - R_IDLE: arready=1. On AR handshake, capture fields and go to R_FETCH.
  - R_FETCH: memory is sampled at the current address. After READ_LAT cycles go to R_DATA.
  - R_DATA: rvalid=1 with rid, rdata, rresp and rlast=(count==arlen). All are held stable until rready.
  - On an R handshake: if last, go to R_IDLE; otherwise advance the address and return to R_FETCH.
  - Throughput is one beat per READ_LAT+1 cycles.
- Out-of-range read beats return rdata=0 and rresp=DECERR. Illegal-burst beats return SLVERR.
- The channels are independent: a read and a write may be in flight at once.
- Same-word collision: a read sample and a write in the same cycle returns the old data (read-before-write).
- Reset asserted mid-burst aborts both FSMs immediately. Memory writes already committed remain.

Test Plan:
- INCR write, awaddr=0x100, len=3, data 0xA0..0xA3, full strobes -> bresp=0, bid=awid. INCR read of the same burst returns 0xA0..0xA3 with rlast on beat 4 only.
- WRAP read, len=3, araddr=0x130 (DATA_W=128) -> beat addresses 0x130, 0x100, 0x110, 0x120; rresp=0.
- Write with wstrb=16'h00FF over 0x11..11, then read -> upper 8 bytes retain old data and lower 8 bytes read 0x11.
- Write at address bit MEM_AW+4 set -> bresp=DECERR and memory unchanged. Read of the same address -> rdata=0, rresp=DECERR.
- Concurrent 8-beat read and 8-beat write to different addresses with rready/bready randomly low -> both complete, data correct, rvalid/rdata stable while stalled.
- Reset asserted during beat 2 of a len=7 read -> rvalid=0 immediately. Next read completes normally; previously written data is still intact.
